// File: rtl/f2_f3_pkg.sv
// Shared constants for the F2/F3 evaluator: truth masks indexed by minterm {a,b,c}.
package f2_f3_pkg;

   localparam logic [7:0] F2_MASK = 8'hAD;  // Σm(0,2,3,5,7)
   localparam logic [7:0] F3_MASK = 8'hD2;  // Σm(1,4,6,7)

   function automatic logic mask_bit(input logic [7:0] mask, input logic a, input logic b,
                                     input logic c);
      logic [2:0] idx;
      idx = {a, b, c};
      return mask[idx];
   endfunction

endpackage

// File: rtl/f2_f3_impl_if.sv
// Function inputs and registered results of the F2/F3 evaluator.
interface f2_f3_if;
   logic a;
   logic b;
   logic c;
   logic f2;
   logic f3;
   logic err;

   modport master (output a, output b, output c, input f2, input f3, input err);
   modport slave  (input a, input b, input c, output f2, output f3, output err);
endinterface

// File: rtl/f2_f3_gate_net.sv
// Gate-level SOP, NAND-NAND and NOR-NOR realisations of F2 and F3.
module f2_f3_gate_net (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic f2_sop,
   output logic f2_nand,
   output logic f2_nor,
   output logic f3_sop,
   output logic f3_nand,
   output logic f3_nor
);

   logic na, nb, nc;
   logic s2_0, s2_1, s2_2, s3_0, s3_1, s3_2;
   logic na_n, nb_n, nc_n;
   logic n2_0, n2_1, n2_2, n3_0, n3_1, n3_2;
   logic na_r, nb_r, nc_r;
   logic r2_0, r2_1, r3_0, r3_1, r3_2;

   not  g_na (na, a);
   not  g_nb (nb, b);
   not  g_nc (nc, c);

   // F2 = a'c' + a'b + ac ; F3 = a'b'c + ab + ac'
   and  g_s20 (s2_0, na, nc);
   and  g_s21 (s2_1, na, b);
   and  g_s22 (s2_2, a, c);
   or   g_s2  (f2_sop, s2_0, s2_1, s2_2);
   and  g_s30 (s3_0, na, nb, c);
   and  g_s31 (s3_1, a, b);
   and  g_s32 (s3_2, a, nc);
   or   g_s3  (f3_sop, s3_0, s3_1, s3_2);

   nand g_ina (na_n, a, a);
   nand g_inb (nb_n, b, b);
   nand g_inc (nc_n, c, c);
   nand g_n20 (n2_0, na_n, nc_n);
   nand g_n21 (n2_1, na_n, b);
   nand g_n22 (n2_2, a, c);
   nand g_n2  (f2_nand, n2_0, n2_1, n2_2);
   nand g_n30 (n3_0, na_n, nb_n, c);
   nand g_n31 (n3_1, a, b);
   nand g_n32 (n3_2, a, nc_n);
   nand g_n3  (f3_nand, n3_0, n3_1, n3_2);

   // POS forms: F2 = (a+b+c')(a'+c) ; F3 = (a+c)(a+b')(a'+b+c')
   nor  g_rna (na_r, a, a);
   nor  g_rnb (nb_r, b, b);
   nor  g_rnc (nc_r, c, c);
   nor  g_r20 (r2_0, a, b, nc_r);
   nor  g_r21 (r2_1, na_r, c);
   nor  g_r2  (f2_nor, r2_0, r2_1);
   nor  g_r30 (r3_0, a, c);
   nor  g_r31 (r3_1, a, nb_r);
   nor  g_r32 (r3_2, na_r, b, nc_r);
   nor  g_r3  (f3_nor, r3_0, r3_1, r3_2);

endmodule

// File: rtl/f2_f3_impl.sv
// Registered F2/F3 evaluator with a sticky cross-check flag over three gate realisations.
module f2_f3_impl (
   input  logic    clk,
   input  logic    rst,
   f2_f3_if.slave  bus
);
   import f2_f3_pkg::*;

   logic f2_sop, f2_nand, f2_nor;
   logic f3_sop, f3_nand, f3_nor;
   logic f2_q, f3_q, err_q;
   logic f2_d, f3_d, err_d;
   logic disagree;

   f2_f3_gate_net u_net (
      .a       (bus.a),
      .b       (bus.b),
      .c       (bus.c),
      .f2_sop  (f2_sop),
      .f2_nand (f2_nand),
      .f2_nor  (f2_nor),
      .f3_sop  (f3_sop),
      .f3_nand (f3_nand),
      .f3_nor  (f3_nor)
   );

   always_comb begin
      disagree = (f2_sop != f2_nand) || (f2_sop != f2_nor) ||
                 (f3_sop != f3_nand) || (f3_sop != f3_nor);
      f2_d     = f2_sop;
      f3_d     = f3_sop;
      err_d    = err_q | disagree;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f2_q  <= 1'b0;
         f3_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         f2_q  <= f2_d;
         f3_q  <= f3_d;
         err_q <= err_d;
      end
   end

   assign bus.f2  = f2_q;
   assign bus.f3  = f3_q;
   assign bus.err = err_q;

endmodule

// File: tb/tb_f2_f3_impl.sv
// Directed and random checks of the F2/F3 evaluator against hand tables and package masks.
module tb_f2_f3_impl;
   import f2_f3_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int unsigned checks = 0;
   int unsigned errors = 0;

   f2_f3_if bus ();

   f2_f3_impl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_bit(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic e2, input logic e3, input logic ee);
      check_bit({tag, ".f2"}, bus.f2, e2);
      check_bit({tag, ".f3"}, bus.f3, e3);
      check_bit({tag, ".err"}, bus.err, ee);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] abc);
      bus.a = abc[2];
      bus.b = abc[1];
      bus.c = abc[0];
   endtask

   logic [7:0] exp_f2_tab;
   logic [7:0] exp_f3_tab;
   logic [2:0] r_abc;
   logic       r_rst;

   initial begin
      // hand-derived truth columns, bit i = minterm i
      exp_f2_tab = 8'b1010_1101;
      exp_f3_tab = 8'b1101_0010;

      rst = 1'b1;
      drive(3'b111);
      tick();
      check_out("reset1", 1'b0, 1'b0, 1'b0);
      tick();
      check_out("reset2", 1'b0, 1'b0, 1'b0);

      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(3'(i));
         tick();
         check_out($sformatf("sweep%0d", i), exp_f2_tab[i], exp_f3_tab[i], 1'b0);
      end

      drive(3'b001);
      #2;
      check_out("hold_pre", 1'b1, 1'b1, 1'b0);
      drive(3'b000);
      tick();
      check_out("hold_edge", 1'b1, 1'b0, 1'b0);

      drive(3'b111);
      tick();
      check_out("mid_pre", 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      check_out("mid_rst", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      check_out("mid_post", 1'b1, 1'b1, 1'b0);

      drive(3'b000);
      force dut.u_net.f2_nand = 1'b0;
      tick();
      check_out("chk_set", 1'b1, 1'b0, 1'b1);
      release dut.u_net.f2_nand;
      tick();
      check_out("chk_sticky", 1'b1, 1'b0, 1'b1);
      rst = 1'b1;
      tick();
      check_out("chk_rst", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      for (int n = 0; n < 1000; n++) begin
         r_abc = 3'($urandom_range(7));
         r_rst = ($urandom_range(99) < 2);
         rst   = r_rst;
         drive(r_abc);
         tick();
         if (r_rst)
            check_out("rand_rst", 1'b0, 1'b0, 1'b0);
         else
            check_out("rand", mask_bit(F2_MASK, r_abc[2], r_abc[1], r_abc[0]),
                      mask_bit(F3_MASK, r_abc[2], r_abc[1], r_abc[0]), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/f2_f3_impl.md
Name: f2_f3_impl

Overview:
- Registered evaluator for two fixed 3-input Boolean functions, F2 and F3, of inputs a, b, c.
- Each function is built in three independent forms: SOP, NAND-only and NOR-only.
- The forms are cross-checked every cycle, and any disagreement raises a sticky error flag.
- Serves as the lab's verified combinational-logic reference block, feeding downstream registered logic.

Parameters:
- None. The truth tables are fixed constants held in the shared package.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  1  function input, MSB of minterm index (index = {a,b,c}).
- b  input  1  function input, middle bit of minterm index.
- c  input  1  function input, LSB of minterm index.
- f2  output  1  registered F2({a,b,c}).
- f3  output  1  registered F3({a,b,c}).
- err  output  1  sticky flag: set when any two implementations of F2, or of F3, disagree.

Behaviour:
- F2 = Σm(0,2,3,5,7) = a'c' + a'b + ac.
  - Truth mask, bit i = minterm i: 8'hAD.
  - F2 = 1 for abc = 000, 010, 011, 101, 111; F2 = 0 for 001, 100, 110.
- F3 = Σm(1,4,6,7) = a'b'c + ab + ac'.
  - Truth mask: 8'hD2.
  - F3 = 1 for abc = 001, 100, 110, 111; F3 = 0 for 000, 010, 011, 101.
- Three combinational implementations per function:
  - SOP using AND/OR/NOT.
  - Two-level NAND-NAND.
  - NOR-only (POS form realised with NOR gates).
- The SOP result is the functional output. The NAND and NOR results are checkers only.
- Latency: exactly 1 cycle.
  - At rising edge k, f2/f3 load the SOP result of the a, b, c values sampled at edge k.
  - Outputs hold until the next edge.
- Inputs are sampled only at clock edges. Changes between edges have no effect.
- err behaviour:
  - Set at an edge if the SOP, NAND and NOR results for F2 are not all equal, or likewise for F3.
  - Once set, err stays 1 until rst.
  - In a correct build err never asserts.
- Reset, when rst = 1 at a rising edge:
  - f2 = 0, f3 = 0, err = 0, regardless of a, b, c.
  - Reset takes priority over the error set.
  - No evaluation is loaded on a reset cycle.
  - The first valid output appears one edge after rst deasserts.
- Reset asserted mid-stream: outputs go to 0 at that edge; prior values are discarded.
- X/Z on inputs is not defined behaviour; the bench drives only 0/1.

Decomposition:
- Package f2_f3_pkg holds:
  - F2_MASK = 8'hAD and F3_MASK = 8'hD2.
  - A function returning mask[{a,b,c}], used by the bench as the golden model.
- One sub-module, f2_f3_gate_net:
  - Purely combinational.
  - Takes a, b, c.
  - Outputs f2_sop, f2_nand, f2_nor, f3_sop, f3_nand, f3_nor, built from gate primitives.
- The top level contains only the registers, the compare logic and the sticky err flag.

Test Plan:
- Reset: rst = 1 for 2 edges with abc = 111 -> f2 = 0, f3 = 0, err = 0 after each edge.
- Exhaustive sweep: release reset, apply abc = 000..111 one per cycle -> one cycle later f2 = 1,0,1,1,0,1,0,1 and f3 = 0,1,0,0,1,0,1,1; err = 0 throughout.
- Latency/hold: change abc between edges (abc = 001 then 000 mid-cycle) -> outputs update only at the next edge and reflect the value present at that edge (f2 = 1, f3 = 0 for 000).
- Reset mid-stream: abc = 111 (f2 = 1, f3 = 1), assert rst for 1 edge -> f2 = 0, f3 = 0; next edge with rst = 0 -> f2 = 1, f3 = 1.
- Checker: force f2_nand = 0 inside the sub-module with abc = 000 -> err = 1 at the next edge; release the force -> err stays 1; assert rst -> err = 0.
- Random: 1000 random cycles with rst asserted at 2% probability -> f2/f3 match the package masks one cycle delayed; err = 0.
